// File: rtl/timer_bus_master_pkg.sv
// Shared definitions for the timer bus master: FSM encoding, beat geometry
// and default peripheral addresses.
package timer_bus_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int         BEAT_COUNT      = 4;
    localparam logic [2:0] DEFAULT_RD_BASE = 3'd4;
    localparam logic [2:0] DEFAULT_WR_ADDR = 3'd0;

    // Byte lane idx of a word, lane 0 being the least-significant byte.
    function automatic logic [7:0] byte_lane(input logic [31:0] word,
                                             input logic [1:0]  idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/timer_bus_master_if.sv
// CPU request/response handshake plus the 8-bit peripheral bus, as seen from
// the bus master (master) and from the CPU/peripheral side (slave).
interface timer_bus_master_if;

    logic        reqValid;
    logic        reqWrite;
    logic [31:0] reqWdata;
    logic        reqReady;
    logic        rspValid;
    logic [31:0] rspRdata;
    logic [2:0]  addressOut;
    logic        read;
    logic        write;
    logic [7:0]  dataOut;
    logic [7:0]  dataIn;

    modport master (
        input  reqValid, reqWrite, reqWdata, dataIn,
        output reqReady, rspValid, rspRdata, addressOut, read, write, dataOut
    );

    modport slave (
        output reqValid, reqWrite, reqWdata, dataIn,
        input  reqReady, rspValid, rspRdata, addressOut, read, write, dataOut
    );

endinterface

// File: rtl/timer_bus_master_irq.sv
// Rising-edge detector on the peripheral IRQ feeding a sticky pending flag
// that the CPU clears with irqAck; a new edge beats a simultaneous ack.
module irq_edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic IRQ,
    input  logic irqAck,
    output logic irqPending
);

    logic irq_q;
    logic irq_d;
    logic pending_q;
    logic pending_d;
    logic irq_rise;

    always_comb begin
        irq_d     = IRQ;
        irq_rise  = IRQ & ~irq_q;
        pending_d = pending_q;
        if (irq_rise) begin
            pending_d = 1'b1;
        end else if (irqAck) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            irq_q     <= irq_d;
            pending_q <= pending_d;
        end
    end

    assign irqPending = pending_q;

endmodule

// File: rtl/timer_bus_master.sv
// Serialises 32-bit CPU reads/writes into four byte beats on the 8-bit
// timer peripheral bus, and latches peripheral interrupt edges.
module timer_bus_master
    import timer_bus_master_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [2:0]  RD_BASE     = DEFAULT_RD_BASE,
    parameter logic [2:0]  WR_ADDR     = DEFAULT_WR_ADDR
) (
    input  logic                      clk,
    input  logic                      rst,
    timer_bus_master_if.master        bus,
    input  logic                      IRQ,
    input  logic                      irqAck,
    output logic                      irqPending
);

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES);
    localparam logic [1:0] LAST_BEAT = 2'(BEAT_COUNT - 1);

    state_e      state_q,     state_d;
    logic [1:0]  beat_q,      beat_d;
    logic [2:0]  wait_cnt_q,  wait_cnt_d;
    logic        is_write_q,  is_write_d;
    logic [31:0] wdata_q,     wdata_d;
    logic [31:0] rdata_q,     rdata_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        strobe;

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        wait_cnt_d   = wait_cnt_q;
        is_write_d   = is_write_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        rsp_rdata_d  = rsp_rdata_q;
        strobe       = 1'b0;
        bus.reqReady   = 1'b0;
        bus.rspValid   = 1'b0;
        bus.addressOut = 3'd0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.dataOut    = 8'd0;

        case (state_q)
            ST_IDLE: begin
                bus.reqReady = 1'b1;
                if (bus.reqValid) begin
                    is_write_d = bus.reqWrite;
                    wdata_d    = bus.reqWdata;
                    rdata_d    = 32'd0;
                    beat_d     = 2'd0;
                    wait_cnt_d = 3'd0;
                    state_d    = ST_BEAT;
                end
            end

            ST_BEAT: begin
                // Address and data sit still for the whole beat; only the
                // final wait cycle carries the one-cycle strobe.
                strobe = (wait_cnt_q == WAIT_LAST);
                if (is_write_q) begin
                    bus.addressOut = WR_ADDR;
                    bus.dataOut    = byte_lane(wdata_q, beat_q);
                    bus.write      = strobe;
                end else begin
                    bus.addressOut = RD_BASE + {1'b0, beat_q};
                    bus.read       = strobe;
                    if (strobe) begin
                        rdata_d[{beat_q, 3'b000} +: 8] = bus.dataIn;
                    end
                end

                if (strobe) begin
                    wait_cnt_d = 3'd0;
                    beat_d     = beat_q + 2'd1;
                    if (beat_q == LAST_BEAT) begin
                        state_d     = ST_RESP;
                        rsp_rdata_d = is_write_q ? 32'd0 : rdata_d;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end

            ST_RESP: begin
                bus.rspValid = 1'b1;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= 2'd0;
            wait_cnt_q  <= 3'd0;
            is_write_q  <= 1'b0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            wait_cnt_q  <= wait_cnt_d;
            is_write_q  <= is_write_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.rspRdata = rsp_rdata_q;

    irq_edge_latch u_irq (
        .clk        (clk),
        .rst        (rst),
        .IRQ        (IRQ),
        .irqAck     (irqAck),
        .irqPending (irqPending)
    );

endmodule

// File: tb/tb_timer_bus_master.sv
// Directed bench for two timer_bus_master instances (0 and 2 wait states),
// checked every cycle against a transaction-level model of the bus timing.
module tb_timer_bus_master;

   localparam int W0 = 0;
   localparam int W1 = 2;

   logic clk = 1'b1;
   logic rst;
   logic IRQ;
   logic irqAck;
   logic pend0;
   logic pend1;

   timer_bus_master_if bus0 ();
   timer_bus_master_if bus1 ();

   logic [7:0]  mem [8];
   logic [31:0] sh0;
   logic [31:0] sh1;

   int nCompared   = 0;
   int nMismatched = 0;
   int cyc         = 0;

   // Transaction model state: phase k counts cycles since acceptance
   // (0 = idle, 1..N = beat cycles, N+1 = response cycle).
   int          k [2];
   bit          op [2];
   logic [31:0] wd [2];
   logic [31:0] expRsp [2];
   bit          expPend;
   bit          prevIrq;

   int          rspCount [2];
   int          strobeCount [2];
   int          readyLow [2];
   int          lastRspCycle [2];
   logic [31:0] lastRspData [2];
   logic [11:0] strobeAddrs [2];
   int          acc0 [$];
   int          acc1 [$];

   always #5 clk = ~clk;

   assign bus0.dataIn = mem[bus0.addressOut];
   assign bus1.dataIn = mem[bus1.addressOut];

   // Peripheral load register: each write byte enters at the top and shifts right.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sh0 <= 32'd0;
         sh1 <= 32'd0;
      end else begin
         if (bus0.write) sh0 <= {bus0.dataOut, sh0[31:8]};
         if (bus1.write) sh1 <= {bus1.dataOut, sh1[31:8]};
      end
   end

   timer_bus_master #(.WAIT_STATES(W0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0), .IRQ(IRQ), .irqAck(irqAck), .irqPending(pend0)
   );

   timer_bus_master #(.WAIT_STATES(W1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .IRQ(IRQ), .irqAck(irqAck), .irqPending(pend1)
   );

   // Single comparison point: every check in the bench goes through here.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] readWord();
      return {mem[7], mem[6], mem[5], mem[4]};
   endfunction

   // Derives each instance's outputs from the cycle offset since acceptance.
   task automatic modelCompare(input int d);
      int w, n, b;
      bit s, reqV, reqW;
      logic [31:0] reqD;
      logic eReady, eRsp, eRd, eWr;
      logic [2:0] eAddr;
      logic [7:0] eData;
      logic aReady, aRsp, aRd, aWr;
      logic [2:0] aAddr;
      logic [7:0] aData;
      logic [31:0] aRdata;
      if (d == 0) begin
         {aReady, aRsp, aRd, aWr} = {bus0.reqReady, bus0.rspValid, bus0.read, bus0.write};
         aAddr = bus0.addressOut; aData = bus0.dataOut; aRdata = bus0.rspRdata;
         reqV = bus0.reqValid; reqW = bus0.reqWrite; reqD = bus0.reqWdata;
         w = W0;
      end else begin
         {aReady, aRsp, aRd, aWr} = {bus1.reqReady, bus1.rspValid, bus1.read, bus1.write};
         aAddr = bus1.addressOut; aData = bus1.dataOut; aRdata = bus1.rspRdata;
         reqV = bus1.reqValid; reqW = bus1.reqWrite; reqD = bus1.reqWdata;
         w = W1;
      end
      n = 4 * (w + 1);
      if (rst) begin
         k[d] = 0;
         expRsp[d] = 32'd0;
      end
      eReady = 1'b0; eRsp = 1'b0; eRd = 1'b0; eWr = 1'b0; eAddr = 3'd0; eData = 8'd0;
      if (k[d] == 0) begin
         eReady = 1'b1;
      end else if (k[d] <= n) begin
         b = (k[d] - 1) / (w + 1);
         s = ((k[d] - 1) % (w + 1)) == w;
         eAddr = op[d] ? 3'd0 : 3'(4 + b);
         eData = op[d] ? 8'(wd[d] >> (8 * b)) : 8'd0;
         eWr = s && op[d];
         eRd = s && !op[d];
      end else begin
         eRsp = 1'b1;
         expRsp[d] = op[d] ? 32'd0 : readWord();
      end
      checkOutput($sformatf("dut%0d.reqReady", d), 32'(aReady), 32'(eReady));
      checkOutput($sformatf("dut%0d.rspValid", d), 32'(aRsp), 32'(eRsp));
      checkOutput($sformatf("dut%0d.read", d), 32'(aRd), 32'(eRd));
      checkOutput($sformatf("dut%0d.write", d), 32'(aWr), 32'(eWr));
      checkOutput($sformatf("dut%0d.addressOut", d), 32'(aAddr), 32'(eAddr));
      checkOutput($sformatf("dut%0d.dataOut", d), 32'(aData), 32'(eData));
      checkOutput($sformatf("dut%0d.rspRdata", d), aRdata, expRsp[d]);

      if (aRsp === 1'b1) begin
         rspCount[d]++;
         lastRspCycle[d] = cyc;
         lastRspData[d] = aRdata;
      end
      if (aRd === 1'b1 || aWr === 1'b1) begin
         strobeCount[d]++;
         strobeAddrs[d] = {strobeAddrs[d][8:0], aAddr};
      end
      if (aReady !== 1'b1) readyLow[d]++;

      if (rst) begin
         k[d] = 0;
      end else if (k[d] == 0) begin
         if (reqV) begin
            k[d] = 1;
            op[d] = reqW;
            wd[d] = reqD;
            if (d == 0) acc0.push_back(cyc); else acc1.push_back(cyc);
         end
      end else if (k[d] == n + 1) begin
         k[d] = 0;
      end else begin
         k[d]++;
      end
   endtask

   task automatic irqCompare();
      bit rise;
      if (rst) begin
         expPend = 1'b0;
         prevIrq = 1'b0;
      end
      checkOutput("dut0.irqPending", 32'(pend0), 32'(expPend));
      checkOutput("dut1.irqPending", 32'(pend1), 32'(expPend));
      if (!rst) begin
         rise = IRQ && !prevIrq;
         if (rise) expPend = 1'b1;
         else if (irqAck) expPend = 1'b0;
         prevIrq = IRQ;
      end
   endtask

   task automatic stepCycle();
      @(negedge clk);
      modelCompare(0);
      modelCompare(1);
      irqCompare();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) stepCycle();
   endtask

   // Presents one request for a single cycle, then lets the transfer run.
   task automatic applyStimulus(input int d, input bit wr, input logic [31:0] data, input int cycles);
      if (d == 0) begin
         bus0.reqValid = 1'b1; bus0.reqWrite = wr; bus0.reqWdata = data;
      end else begin
         bus1.reqValid = 1'b1; bus1.reqWrite = wr; bus1.reqWdata = data;
      end
      stepCycle();
      bus0.reqValid = 1'b0;
      bus1.reqValid = 1'b0;
      runCycles(cycles);
   endtask

   initial begin
      bit          b2bWr [4];
      logic [31:0] b2bData [4];
      int rc, sc, rl, n0, idx;

      b2bWr = '{1'b1, 1'b0, 1'b1, 1'b0};
      b2bData = '{32'hCAFEF00D, 32'h0, 32'h0BADBEEF, 32'h0};
      for (int i = 0; i < 8; i++) mem[i] = 8'hE0 + 8'(i);
      mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
      for (int d = 0; d < 2; d++) begin
         k[d] = 0; op[d] = 1'b0; wd[d] = 32'd0; expRsp[d] = 32'd0;
         rspCount[d] = 0; strobeCount[d] = 0; readyLow[d] = 0;
         lastRspCycle[d] = -1; lastRspData[d] = 32'd0; strobeAddrs[d] = 12'd0;
      end
      expPend = 1'b0; prevIrq = 1'b0;
      rst = 1'b1; IRQ = 1'b0; irqAck = 1'b0;
      bus0.reqValid = 1'b0; bus0.reqWrite = 1'b0; bus0.reqWdata = 32'd0;
      bus1.reqValid = 1'b0; bus1.reqWrite = 1'b0; bus1.reqWdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] reset state");
      stepCycle();
      checkOutput("reset reqReady", 32'(bus0.reqReady), 32'd1);
      checkOutput("reset rspValid", 32'(bus0.rspValid), 32'd0);
      checkOutput("reset rspRdata", bus1.rspRdata, 32'd0);
      rst = 1'b0;
      runCycles(2);

      $display("[TB] write 0xA1B2C3D4, no wait states");
      rc = rspCount[0]; sc = strobeCount[0];
      applyStimulus(0, 1'b1, 32'hA1B2C3D4, 8);
      checkOutput("wr latency", 32'(lastRspCycle[0] - acc0[$]), 32'd5);
      checkOutput("wr rsp count", 32'(rspCount[0] - rc), 32'd1);
      checkOutput("wr strobes", 32'(strobeCount[0] - sc), 32'd4);
      checkOutput("wr shift reg", sh0, 32'hA1B2C3D4);

      $display("[TB] read 4..7");
      applyStimulus(0, 1'b0, 32'hFFFFFFFF, 8);
      checkOutput("rd latency", 32'(lastRspCycle[0] - acc0[$]), 32'd5);
      checkOutput("rd word", lastRspData[0], 32'h44332211);
      checkOutput("rd addresses", 32'(strobeAddrs[0]), 32'(12'o4567));

      $display("[TB] write 0x00000001, two wait states");
      rc = rspCount[1]; sc = strobeCount[1]; rl = readyLow[1];
      applyStimulus(1, 1'b1, 32'h00000001, 16);
      checkOutput("ws latency", 32'(lastRspCycle[1] - acc1[$]), 32'd13);
      checkOutput("ws strobes", 32'(strobeCount[1] - sc), 32'd4);
      checkOutput("ws ready low", 32'(readyLow[1] - rl), 32'd13);
      checkOutput("ws rsp count", 32'(rspCount[1] - rc), 32'd1);
      checkOutput("ws shift reg", sh1, 32'h00000001);

      $display("[TB] reset during beat-2 read strobe");
      rc = rspCount[0];
      applyStimulus(0, 1'b0, 32'd0, 2);
      checkOutput("pre-reset read", 32'(bus0.read), 32'd1);
      checkOutput("pre-reset addr", 32'(bus0.addressOut), 32'd6);
      rst = 1'b1;
      #1;
      checkOutput("abort read", 32'(bus0.read), 32'd0);
      checkOutput("abort addr", 32'(bus0.addressOut), 32'd0);
      checkOutput("abort ready", 32'(bus0.reqReady), 32'd1);
      stepCycle();
      rst = 1'b0;
      runCycles(8);
      checkOutput("abort no rsp", 32'(rspCount[0] - rc), 32'd0);
      mem[4] = 8'h55; mem[5] = 8'h66; mem[6] = 8'h77; mem[7] = 8'h88;
      applyStimulus(0, 1'b0, 32'd0, 8);
      checkOutput("post-reset latency", 32'(lastRspCycle[0] - acc0[$]), 32'd5);
      checkOutput("post-reset word", lastRspData[0], 32'h88776655);

      $display("[TB] interrupt edge latch");
      IRQ = 1'b1; stepCycle(); IRQ = 1'b0;
      checkOutput("irq set", 32'(pend0), 32'd1);
      runCycles(2);
      IRQ = 1'b1; stepCycle();
      irqAck = 1'b1; stepCycle(); irqAck = 1'b0;
      checkOutput("irq ack", 32'(pend0), 32'd0);
      runCycles(3);
      checkOutput("irq level no reset", 32'(pend1), 32'd0);
      IRQ = 1'b0; stepCycle();
      IRQ = 1'b1; irqAck = 1'b1; stepCycle();
      irqAck = 1'b0; IRQ = 1'b0;
      checkOutput("irq set beats ack", 32'(pend0), 32'd1);
      runCycles(2);

      $display("[TB] back-to-back requests");
      n0 = acc0.size();
      idx = 0;
      bus0.reqValid = 1'b1; bus0.reqWrite = b2bWr[0]; bus0.reqWdata = b2bData[0];
      for (int c = 0; c < 40 && idx < 4; c++) begin
         stepCycle();
         if (acc0.size() - n0 > idx) idx++;
         if (idx < 4) begin
            if (k[0] == 0) begin
               bus0.reqWrite = b2bWr[idx]; bus0.reqWdata = b2bData[idx];
            end else begin
               bus0.reqWrite = 1'($urandom); bus0.reqWdata = $urandom;
            end
         end
      end
      bus0.reqValid = 1'b0;
      runCycles(8);
      checkOutput("b2b accepted", 32'(acc0.size() - n0), 32'd4);
      for (int i = 1; i < 4; i++) begin
         if (n0 + i < acc0.size())
            checkOutput($sformatf("b2b spacing %0d", i), 32'(acc0[n0 + i] - acc0[n0 + i - 1]), 32'd6);
      end
      checkOutput("b2b shift reg", sh0, 32'h0BADBEEF);
      checkOutput("b2b read word", lastRspData[0], 32'h88776655);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
